// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: field widths, flit type and an address-field accessor.
// The address occupies the most significant bits of every flit.
package noc_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int FLIT_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    function automatic logic [ADDR_WIDTH-1:0] noc_addr(input flit_t f);
        return f[FLIT_WIDTH-1 -: ADDR_WIDTH];
    endfunction

endpackage

// File: rtl/noc_flit_mux.sv
// Generic N:1 flit selector, shared by the input queues and the crossbar outputs.
// Latency: purely combinational. Backpressure: none; a select value >= N yields zero.
module noc_flit_mux
    import noc_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = FLIT_WIDTH
) (
    input  logic [N-1:0][WIDTH-1:0] Input_Vector,
    input  logic [$clog2(N)-1:0]    Sel,
    output logic [WIDTH-1:0]        Output_Vector
);

    localparam int SW = $clog2(N);

    // Match against each legal index so out-of-range selects fall through to zero.
    always_comb begin
        Output_Vector = '0;
        for (int i = 0; i < N; i++) begin
            if (Sel == SW'(i)) begin
                Output_Vector = Input_Vector[i];
            end
        end
    end

endmodule

// File: rtl/noc_flit_fifo.sv
// Show-ahead per-port input flit queue; head flit always presented on data_out.
// Latency: one cycle write-to-read. Backpressure: writes dropped while full, reads ignored while empty.
// Optional FIFO_ERR_FLAG_EN adds a sticky err output flagging overflow/underflow attempts.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = FLIT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [WIDTH-1:0] data_in,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef FIFO_ERR_FLAG_EN
    ,
    output logic             err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] storage;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic                        do_wr;
    logic                        do_rd;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = we & ~full;
    assign do_rd = re & ~empty;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            storage <= '0;
        end else if (do_wr) begin
            storage[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err <= 1'b0;
        end else if ((we & full) | (re & empty)) begin
            err <= 1'b1;
        end
    end
`endif

    noc_flit_mux #(
        .N     (DEPTH),
        .WIDTH (WIDTH)
    ) u_rd_mux (
        .Input_Vector  (storage),
        .Sel           (rd_ptr),
        .Output_Vector (data_out)
    );

endmodule

// File: tb/tb_noc_flit_fifo.sv
// Bench for noc_flit_fifo: directed boundary steps plus random traffic against a queue model.
module tb_noc_flit_fifo;

    localparam int DEPTH = 2;
    localparam int W     = 20;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [W-1:0] data_out;
    logic         full;
    logic         empty;
`ifdef FIFO_ERR_FLAG_EN
    logic         err;
    bit           err_m = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] model[$];

    logic [3:0][W-1:0] mux4_in;
    logic [1:0]        mux4_sel;
    logic [W-1:0]      mux4_out;
    logic [2:0][W-1:0] mux3_in;
    logic [1:0]        mux3_sel;
    logic [W-1:0]      mux3_out;

    always #5 clk = ~clk;

    noc_flit_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .data_in  (data_in),
        .we       (we),
        .re       (re),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef FIFO_ERR_FLAG_EN
        ,
        .err      (err)
`endif
    );

    noc_flit_mux #(.N(4), .WIDTH(W)) u_mux4 (
        .Input_Vector  (mux4_in),
        .Sel           (mux4_sel),
        .Output_Vector (mux4_out)
    );

    noc_flit_mux #(.N(3), .WIDTH(W)) u_mux3 (
        .Input_Vector  (mux3_in),
        .Sel           (mux3_sel),
        .Output_Vector (mux3_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(model.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(model.size() == DEPTH));
        if (model.size() > 0) chk({tag, ".head"}, 32'(data_out), 32'(model[0]));
`ifdef FIFO_ERR_FLAG_EN
        chk({tag, ".err"}, 32'(err), 32'(err_m));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"},  32'(full),  32'd0);
        chk({tag, ".dout"},  32'(data_out), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
        chk({tag, ".err"}, 32'(err), 32'd0);
`endif
    endtask

    // One clock of traffic; the model applies the queue rules to the pre-edge occupancy.
    task automatic step(input string tag, input logic w, input logic r, input logic [W-1:0] d);
        bit pre_full;
        bit pre_empty;
        we = w;
        re = r;
        data_in = d;
        pre_full  = (model.size() == DEPTH);
        pre_empty = (model.size() == 0);
        @(posedge clk);
        #1;
        if (r && !pre_empty) void'(model.pop_front());
        if (w && !pre_full) model.push_back(d);
`ifdef FIFO_ERR_FLAG_EN
        if ((w && pre_full) || (r && pre_empty)) err_m = 1'b1;
`endif
        we = 1'b0;
        re = 1'b0;
        check_state(tag);
    endtask

    initial begin
        // Reset and release
        #12;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst_l = 1'b1;
        #1;
        check_reset_outputs("rst_rel");

        // Fill to full, head stays on first flit
        step("wr1", 1'b1, 1'b0, 20'h1AAAA);
        chk("wr1.dout", 32'(data_out), 32'h1AAAA);
        step("wr2", 1'b1, 1'b0, 20'h2BBBB);
        chk("wr2.full", 32'(full), 32'd1);
        chk("wr2.dout", 32'(data_out), 32'h1AAAA);

        // Overflow attempt, then drain
        step("ovf", 1'b1, 1'b0, 20'hFFFFF);
        chk("ovf.dout", 32'(data_out), 32'h1AAAA);
        step("rd1", 1'b0, 1'b1, '0);
        chk("rd1.dout", 32'(data_out), 32'h2BBBB);
        step("rd2", 1'b0, 1'b1, '0);
        chk("rd2.empty", 32'(empty), 32'd1);

        // Full with simultaneous we/re: write dropped, read proceeds
        step("f1", 1'b1, 1'b0, 20'h10001);
        step("f2", 1'b1, 1'b0, 20'h10002);
        step("fwr", 1'b1, 1'b1, 20'h3CCCC);
        chk("fwr.dout", 32'(data_out), 32'h10002);
        step("fdr", 1'b0, 1'b1, '0);

        // One entry, concurrent we/re for five cycles
        step("pre", 1'b1, 1'b0, 20'h00000);
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("wr_rd%0d", i), 1'b1, 1'b1, 20'(i));
            chk($sformatf("wr_rd%0d.dout", i), 32'(data_out), 32'(i));
        end
        step("drn", 1'b0, 1'b1, '0);

        // Underflow attempts
        step("uf", 1'b0, 1'b1, '0);
        step("ufw", 1'b1, 1'b1, 20'h4CCCC);
        chk("ufw.dout", 32'(data_out), 32'h4CCCC);
        step("idle", 1'b0, 1'b0, '0);

        // Asynchronous reset while full, between clock edges
        step("rf", 1'b1, 1'b0, 20'h5DDDD);
        chk("rf.full", 32'(full), 32'd1);
        #2;
        rst_l = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model.delete();
`ifdef FIFO_ERR_FLAG_EN
        err_m = 1'b0;
`endif
        @(negedge clk);
        rst_l = 1'b1;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom), 1'($urandom), W'($urandom));
        end

        // Mux selection
        mux4_in = {20'h44444, 20'h33333, 20'h22222, 20'h11111};
        for (int s = 0; s < 4; s++) begin
            mux4_sel = 2'(s);
            #1;
            chk($sformatf("mux4.sel%0d", s), 32'(mux4_out), 32'(20'h11111 * (s + 1)));
        end
        mux3_in = {20'hCCCCC, 20'hBBBBB, 20'hAAAAA};
        mux3_sel = 2'd2;
        #1;
        chk("mux3.sel2", 32'(mux3_out), 32'hCCCCC);
        mux3_sel = 2'd3;
        #1;
        chk("mux3.oob", 32'(mux3_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
